brick_field: RTL
================

# brick_field

Brick-state and collision stage feeding the brick renderer. Holds the alive mask for the single row of five bricks. Once per frame it tests the ball's bounding box against each live brick and clears the first one hit. Exports the mask the renderer uses to suppress dead bricks, plus hit, bounce and score information for the ball-motion logic.

## Interface
Parameters:
- NUM_BRICKS, 5, bricks in the row (mask width)
- BRICK_W, 124, brick width in pixels
- BRICK_H, 20, brick height in pixels
- BRICK_PITCH, 128, x distance between brick left edges; brick i spans x in [i*BRICK_PITCH, i*BRICK_PITCH+BRICK_W)
- ROW_Y, 4, top y of the row; row spans y in [ROW_Y, ROW_Y+BRICK_H)
- BALL_SIZE, 8, ball square edge in pixels

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  reset, asynchronous, active-low
- frame_start  in  1  one-cycle pulse at start of vertical blank
- ball_x  in  10  ball top-left x, sampled on frame_start
- ball_y  in  10  ball top-left y, sampled on frame_start
- level_reload  in  1  one-cycle pulse; restores all bricks
- alive  out  NUM_BRICKS  bit i = 1 when brick i is present
- check_done  out  1  one-cycle pulse when a frame's scan completes
- hit  out  1  one-cycle pulse, coincident with check_done, when a brick was cleared
- hit_index  out  3  index of the cleared brick, valid while hit = 1
- score  out  8  count of bricks cleared, saturating at 255
- all_cleared  out  1  high while alive == 0

## Operation
- FSM states: IDLE, SCAN, REPORT.
- IDLE: on frame_start, latch ball_x/ball_y, set scan index to 0, clear the hit-found flag, go to SCAN.
- SCAN: test brick `idx` each cycle.
  - Test: alive[idx] and the ball box [bx, bx+BALL_SIZE) x [by, by+BALL_SIZE) overlaps the brick rectangle (strict half-open intervals).
  - All compares are 11-bit zero-extended, so bx+BALL_SIZE near 1023 cannot wrap.
  - On the first overlap, latch hit_index = idx, set the found flag, and clear alive[idx] in that cycle. Later overlaps in the same scan are ignored: at most one brick per frame, lowest index wins.
  - After idx = NUM_BRICKS-1, go to REPORT.
- REPORT: pulse check_done. If found, pulse hit and increment score (saturating). Return to IDLE.
- frame_start while in SCAN or REPORT is ignored (not queued).
- level_reload has priority in any state:
  - alive <= all ones, FSM -> IDLE, any scan in progress is aborted with no check_done or hit.
  - score is unchanged.
  - Reload coincident with frame_start: reload wins and frame_start is dropped.
- all_cleared is registered and updates the cycle after alive changes.
- Reset values: alive = all ones, score = 0, check_done = 0, hit = 0, hit_index = 0, all_cleared = 0, state IDLE.

## Timing
- frame_start at cycle 0. SCAN occupies cycles 1..NUM_BRICKS (1..5). check_done and hit are high in cycle NUM_BRICKS+1 (6).
- An alive bit drops on the clock edge that ends the scan cycle for that brick, i.e. up to 4 cycles before hit. The renderer samples alive only during active video, so the mid-blank update is invisible.
- score updates on the edge ending REPORT. It is visible the cycle after hit.
- Back-to-back frames: the next frame_start is accepted from cycle 7 onward.
- Reset asserted mid-scan: all state returns to reset values immediately (asynchronous). No pulse is emitted.

## Structure
- Package brick_pkg holds:
  - the geometry constants (NUM_BRICKS, BRICK_W, BRICK_H, BRICK_PITCH, ROW_Y, BALL_SIZE), shared with the renderer so both agree on brick placement;
  - the FSM state enum.
- Sub-module brick_hit_test: purely combinational rectangle-overlap check. Inputs are ball x/y and brick x/y; output is overlap. It is instantiated once and muxed by scan index.

## Test plan
- Reset release, no stimulus -> alive = 5'b11111, score = 0, all_cleared = 0, no pulses.
- Ball (200,10), frame_start -> cycle 6: check_done = 1, hit = 1, hit_index = 1; alive = 5'b11101; score = 1.
- Ball (122,10) straddles bricks 0 and 1 -> only brick 0 cleared, alive = 5'b11110, hit_index = 0. Repeat the same ball next frame -> brick 1 cleared.
- Ball (124,10) sits in the gap at x 124..127? No: box [124,132) overlaps brick 1 at 128 -> hit_index = 1. Ball (0,24) is just below the row -> check_done = 1, hit = 0, alive unchanged.
- Clear all five over five frames -> score = 5, all_cleared = 1. level_reload -> alive = 5'b11111, score = 5, all_cleared = 0.
- level_reload at cycle 3 of a scan -> no check_done, alive = 5'b11111. rst low at cycle 2 -> all outputs at reset values immediately. frame_start at cycle 4 of a scan -> ignored, exactly one check_done.

Source files
------------

// File: rtl/brick_pkg.sv
// Shared brick-row geometry and FSM state encoding.
// Imported by the collision stage and the renderer.
package brick_pkg;

    localparam int NUM_BRICKS  = 5;
    localparam int BRICK_W     = 124;
    localparam int BRICK_H     = 20;
    localparam int BRICK_PITCH = 128;
    localparam int ROW_Y       = 4;
    localparam int BALL_SIZE   = 8;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        REPORT
    } state_e;

    function automatic logic [10:0] brick_left(
        input logic [2:0] idx,
        input int         pitch
    );
        return 11'(idx) * 11'(pitch);
    endfunction

endpackage

// File: rtl/brick_hit_test.sv
// Combinational ball-box vs brick-rectangle overlap test.
// Half-open intervals, 11-bit compares so ball_x+size never wraps.
module brick_hit_test
    import brick_pkg::*;
#(
    parameter int BRICK_W   = brick_pkg::BRICK_W,
    parameter int BRICK_H   = brick_pkg::BRICK_H,
    parameter int BALL_SIZE = brick_pkg::BALL_SIZE
) (
    input  logic [9:0]  ball_x_i,
    input  logic [9:0]  ball_y_i,
    input  logic [10:0] brick_x_i,
    input  logic [10:0] brick_y_i,
    output logic        overlap_o
);

    logic [10:0] bx;
    logic [10:0] by;
    logic        ovl_x;
    logic        ovl_y;

    assign bx = {1'b0, ball_x_i};
    assign by = {1'b0, ball_y_i};

    assign ovl_x = (bx < brick_x_i + 11'(BRICK_W)) &&
                   (bx + 11'(BALL_SIZE) > brick_x_i);
    assign ovl_y = (by < brick_y_i + 11'(BRICK_H)) &&
                   (by + 11'(BALL_SIZE) > brick_y_i);

    assign overlap_o = ovl_x && ovl_y;

endmodule

// File: rtl/brick_field.sv
// Brick alive mask and once-per-frame collision scan.
// Clears at most one brick per frame (lowest index wins).
module brick_field
    import brick_pkg::*;
#(
    parameter int NUM_BRICKS  = brick_pkg::NUM_BRICKS,
    parameter int BRICK_W     = brick_pkg::BRICK_W,
    parameter int BRICK_H     = brick_pkg::BRICK_H,
    parameter int BRICK_PITCH = brick_pkg::BRICK_PITCH,
    parameter int ROW_Y       = brick_pkg::ROW_Y,
    parameter int BALL_SIZE   = brick_pkg::BALL_SIZE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_start,
    input  logic [9:0]            ball_x,
    input  logic [9:0]            ball_y,
    input  logic                  level_reload,
    output logic [NUM_BRICKS-1:0] alive,
    output logic                  check_done,
    output logic                  hit,
    output logic [2:0]            hit_index,
    output logic [7:0]            score,
    output logic                  all_cleared
);

    localparam logic [2:0] LAST = 3'(NUM_BRICKS - 1);

    state_e                state_q, state_d;
    logic [9:0]            bx_q, bx_d;
    logic [9:0]            by_q, by_d;
    logic [2:0]            idx_q, idx_d;
    logic                  found_q, found_d;
    logic [2:0]            hidx_q, hidx_d;
    logic [NUM_BRICKS-1:0] alive_q, alive_d;
    logic [7:0]            score_q, score_d;
    logic                  clr_q;
    logic                  overlap;

    brick_hit_test #(
        .BRICK_W   (BRICK_W),
        .BRICK_H   (BRICK_H),
        .BALL_SIZE (BALL_SIZE)
    ) u_hit (
        .ball_x_i  (bx_q),
        .ball_y_i  (by_q),
        .brick_x_i (brick_left(idx_q, BRICK_PITCH)),
        .brick_y_i (11'(ROW_Y)),
        .overlap_o (overlap)
    );

    // Next-state: scan sequencing, brick clearing, score, reload override
    always_comb begin
        state_d = state_q;
        bx_d    = bx_q;
        by_d    = by_q;
        idx_d   = idx_q;
        found_d = found_q;
        hidx_d  = hidx_q;
        alive_d = alive_q;
        score_d = score_q;
        unique case (state_q)
            IDLE: begin
                if (frame_start) begin
                    bx_d    = ball_x;
                    by_d    = ball_y;
                    idx_d   = 3'd0;
                    found_d = 1'b0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (!found_q && alive_q[idx_q] && overlap) begin
                    found_d        = 1'b1;
                    hidx_d         = idx_q;
                    alive_d[idx_q] = 1'b0;
                end
                if (idx_q == LAST) begin
                    state_d = REPORT;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            REPORT: begin
                if (found_q && score_q != 8'hFF) begin
                    score_d = score_q + 8'd1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (level_reload) begin
            alive_d = '1;
            score_d = score_q;
            state_d = IDLE;
        end
    end

    // State and datapath registers, asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            bx_q    <= '0;
            by_q    <= '0;
            idx_q   <= '0;
            found_q <= 1'b0;
            hidx_q  <= '0;
            alive_q <= '1;
            score_q <= '0;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            idx_q   <= idx_d;
            found_q <= found_d;
            hidx_q  <= hidx_d;
            alive_q <= alive_d;
            score_q <= score_d;
            clr_q   <= (alive_q == '0);
        end
    end

    assign check_done  = (state_q == REPORT) && !level_reload;
    assign hit         = check_done && found_q;
    assign hit_index   = hidx_q;
    assign alive       = alive_q;
    assign score       = score_q;
    assign all_cleared = clr_q;

endmodule
